// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the traffic phase controller and its surroundings.
// Ports: ped_req/flash are requests into the controller; lights/walk/phase/ped_pend
//        are its lamp drives and status. master = requester side, slave = controller.
interface traffic_phase_ctrl_if #(
  parameter int NUM_APPR = 4
);
  logic                    ped_req;
  logic                    flash;
  logic [3*NUM_APPR-1:0]   lights;
  logic [2:0]              walk;
  logic [2:0]              phase;
  logic                    ped_pend;

  modport master (
    output ped_req, flash,
    input  lights, walk, phase, ped_pend
  );

  modport slave (
    input  ped_req, flash,
    output lights, walk, phase, ped_pend
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic signal controller: fixed rotation green/yellow/all-red, optional
// pedestrian walk phase after the last approach, and a flash mode; timing from an internal tick.
// Ports: clk, rst (async, active-high); bus.slave carries ped_req/flash in, lights/walk/phase/ped_pend out.
module traffic_phase_ctrl #(
  parameter int NUM_APPR = 4,
  parameter int TICK_DIV = 50000000,
  parameter int GREEN_T  = 15,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 10,
  parameter int TMR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_phase_ctrl_if.slave  bus
);

  localparam int              PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0] T_GREEN  = TMR_W'(GREEN_T - 1);
  localparam logic [TMR_W-1:0] T_YELLOW = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] T_ALLRED = TMR_W'(ALLRED_T - 1);
  localparam logic [TMR_W-1:0] T_WALK   = TMR_W'(WALK_T - 1);
  localparam logic [2:0]      LAST_PH  = 3'(NUM_APPR - 1);
  localparam logic [2:0]      C_R      = 3'b100;
  localparam logic [2:0]      C_G      = 3'b010;
  localparam logic [2:0]      C_Y      = 3'b001;

  typedef enum logic [2:0] {
    S_GREEN, S_YELLOW, S_ALLRED, S_WALK, S_WALK_CLR, S_FLASH
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [2:0]        phase_q, phase_d;
  logic              pend_q, pend_d;
  logic              flash_lvl_q, flash_lvl_d;
  logic [PS_W-1:0]   ps_cnt;
  logic              tick;
  logic [3*NUM_APPR-1:0] lights_c;
  logic [2:0]        walk_c;

  // Prescaler: one-clk tick every TICK_DIV clocks.
  assign tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + PS_W'(1);
  end

  // State register. Reset parks in all-red on the last approach so approach 0 is served first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ALLRED;
      timer_q     <= T_ALLRED;
      phase_q     <= LAST_PH;
      pend_q      <= 1'b0;
      flash_lvl_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      flash_lvl_q <= flash_lvl_d;
    end
  end

  // Next-state logic: flash overrides everything, then timer expiry, then pedestrian latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
    flash_lvl_d = flash_lvl_q;

    if (!bus.flash && bus.ped_req && state_q != S_WALK && state_q != S_WALK_CLR)
      pend_d = 1'b1;

    if (bus.flash) begin
      state_d = S_FLASH;
      // Flash always opens with the lamps lit, then toggles per tick.
      if (state_q != S_FLASH) flash_lvl_d = 1'b1;
      else if (tick)          flash_lvl_d = ~flash_lvl_q;
    end else if (state_q == S_FLASH) begin
      state_d = S_ALLRED;
      timer_d = T_ALLRED;
      phase_d = LAST_PH;
    end else if (tick) begin
      if (timer_q != '0) begin
        timer_d = timer_q - TMR_W'(1);
      end else begin
        unique case (state_q)
          S_GREEN: begin
            state_d = S_YELLOW;
            timer_d = T_YELLOW;
          end
          S_YELLOW: begin
            state_d = S_ALLRED;
            timer_d = T_ALLRED;
          end
          S_ALLRED: begin
            if (phase_q == LAST_PH && pend_q) begin
              state_d = S_WALK;
              timer_d = T_WALK;
              pend_d  = 1'b0;  // a request on this same clk is dropped
            end else begin
              state_d = S_GREEN;
              timer_d = T_GREEN;
              phase_d = (phase_q == LAST_PH) ? 3'd0 : phase_q + 3'd1;
            end
          end
          S_WALK: begin
            state_d = S_WALK_CLR;
            timer_d = T_YELLOW;
          end
          S_WALK_CLR: begin
            state_d = S_ALLRED;
            timer_d = T_ALLRED;
            phase_d = LAST_PH;
          end
          default: ;
        endcase
      end
    end
  end

  // Moore outputs decoded from registered state; reset forces all-red immediately.
  always_comb begin
    lights_c = {NUM_APPR{C_R}};
    walk_c   = C_R;
    unique case (state_q)
      S_GREEN:    lights_c[3*int'(phase_q) +: 3] = C_G;
      S_YELLOW:   lights_c[3*int'(phase_q) +: 3] = C_Y;
      S_WALK:     walk_c = C_G;
      S_WALK_CLR: walk_c = C_Y;
      S_FLASH:    lights_c = {NUM_APPR{flash_lvl_q ? C_Y : 3'b000}};
      default: ;
    endcase
  end

  assign bus.lights   = lights_c;
  assign bus.walk     = walk_c;
  assign bus.phase    = phase_q;
  assign bus.ped_pend = pend_q;

endmodule
